// File: rtl/aes_block_serializer.sv
// ---------------------------------------------------------------------------
// aes_block_serializer
//
// Purpose:
//   Captures a 128-bit AES block and emits it as four 32-bit words over a
//   valid/ready stream. By default the words leave most-significant first.
//   A new block can be captured on the same cycle the final word of the
//   previous block is accepted, so back-to-back blocks stream without gaps.
//
// Configuration macro:
//   AES_SER_LSW_FIRST_EN - when defined, words are emitted least-significant
//                          first. Handshake, out_last, latency and blk_cnt
//                          behave identically in both builds.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   in_data    in   128  block to emit (bit 127 = MSB)
//   in_valid   in   1    in_data offered for capture
//   in_ready   out  1    block can be captured this cycle
//   out_data   out  32   current word (zero while idle)
//   out_valid  out  1    out_data holds a valid word
//   out_ready  in   1    sink accepts out_data this cycle
//   out_last   out  1    out_data is the final word of the block
//   busy       out  1    a block is held and not fully emitted
//   blk_cnt    out  16   number of fully emitted blocks (wraps at 2^16)
// ---------------------------------------------------------------------------
module aes_block_serializer (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic [15:0]  blk_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   hold_q,  hold_d;
    logic [1:0]     idx_q,   idx_d;
    logic [15:0]    blk_cnt_q, blk_cnt_d;

    logic [31:0]    cur_word;
    logic [127:0]   hold_shifted;
    logic           word_xfer;
    logic           blk_xfer;

    // Word selection and shift direction are the only things the macro
    // changes; everything downstream is order-agnostic.
`ifdef AES_SER_LSW_FIRST_EN
    assign cur_word     = hold_q[31:0];
    assign hold_shifted = {32'd0, hold_q[127:32]};
`else
    assign cur_word     = hold_q[127:96];
    assign hold_shifted = {hold_q[95:0], 32'd0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        blk_cnt_d = blk_cnt_q;

        out_valid = (state_q == SEND);
        out_last  = (state_q == SEND) && (idx_q == 2'd3);
        // Combinational path from out_ready: the slot frees up on the same
        // edge the last word leaves, which is what allows gapless streaming.
        in_ready  = (state_q == IDLE) ||
                    ((state_q == SEND) && (idx_q == 2'd3) && out_ready);
        // Idle output is forced to zero so a stale word never leaks out.
        out_data  = out_valid ? cur_word : 32'd0;
        busy      = (state_q == SEND);

        word_xfer = out_valid && out_ready;
        blk_xfer  = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (blk_xfer) begin
                    hold_d  = in_data;
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (word_xfer) begin
                    if (idx_q != 2'd3) begin
                        hold_d = hold_shifted;
                        idx_d  = idx_q + 2'd1;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 16'd1;
                        if (blk_xfer) begin
                            hold_d = in_data;
                            idx_d  = 2'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_aes_block_serializer.sv
// ---------------------------------------------------------------------------
// tb_aes_block_serializer
//
// Directed bench for aes_block_serializer. Inputs change and outputs are
// sampled on the falling edge; transfers happen on the rising edge.
// Expected word orders follow AES_SER_LSW_FIRST_EN so the same bench serves
// both builds.
// ---------------------------------------------------------------------------
module tb_aes_block_serializer;

    logic         clk;
    logic         rst;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic [15:0]  blk_cnt;

    int passed = 0;
    int total  = 0;

    localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

    logic [31:0] a_exp [4];
    logic [31:0] b_exp [4];

    aes_block_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 32'd0) $display("FAIL reset_out_data got %h want 00000000", out_data); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (blk_cnt !== 16'd0) $display("FAIL reset_blk_cnt got %h want 0000", blk_cnt); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        $display("test_reset: done");
    endtask

    task automatic test_single();
        in_data = BLK_A; in_valid = 1'b1; out_ready = 1'b1;
        total++; if (in_ready !== 1'b1) $display("FAIL single_in_ready got %b want 1", in_ready); else passed++;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL single_valid_w%0d got %b want 1", w, out_valid); else passed++;
            total++; if (out_data !== a_exp[w]) $display("FAIL single_data_w%0d got %h want %h", w, out_data, a_exp[w]); else passed++;
            total++; if (out_last !== (w == 3)) $display("FAIL single_last_w%0d got %b want %b", w, out_last, (w == 3)); else passed++;
            total++; if (busy !== 1'b1) $display("FAIL single_busy_w%0d got %b want 1", w, busy); else passed++;
            $display("single word %0d: %h last=%b", w, out_data, out_last);
            tick();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL single_idle_valid got %b want 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_idle_busy got %b want 0", busy); else passed++;
        total++; if (blk_cnt !== 16'd1) $display("FAIL single_blk_cnt got %h want 0001", blk_cnt); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL single_idle_in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_stall();
        logic pattern [7];
        int k;
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        in_data = BLK_A; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 7; c++) begin
            out_ready = pattern[c];
            total++; if (out_valid !== 1'b1) $display("FAIL stall_valid_c%0d got %b want 1", c, out_valid); else passed++;
            total++; if (out_data !== a_exp[k]) $display("FAIL stall_data_c%0d got %h want %h", c, out_data, a_exp[k]); else passed++;
            total++; if (out_last !== (k == 3)) $display("FAIL stall_last_c%0d got %b want %b", c, out_last, (k == 3)); else passed++;
            $display("stall cycle %0d: ready=%b word=%h", c, out_ready, out_data);
            tick();
            if (pattern[c]) k++;
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL stall_idle_valid got %b want 0", out_valid); else passed++;
        total++; if (blk_cnt !== 16'd2) $display("FAIL stall_blk_cnt got %h want 0002", blk_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        in_data = BLK_A; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_data = BLK_B;
        for (int c = 0; c < 8; c++) begin
            logic [31:0] exp_w;
            exp_w = (c < 4) ? a_exp[c] : b_exp[c - 4];
            total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid_c%0d got %b want 1", c, out_valid); else passed++;
            total++; if (out_data !== exp_w) $display("FAIL b2b_data_c%0d got %h want %h", c, out_data, exp_w); else passed++;
            total++; if (out_last !== ((c % 4) == 3)) $display("FAIL b2b_last_c%0d got %b want %b", c, out_last, ((c % 4) == 3)); else passed++;
            if (c < 4) begin
                total++; if (in_ready !== (c == 3)) $display("FAIL b2b_in_ready_c%0d got %b want %b", c, in_ready, (c == 3)); else passed++;
            end
            $display("b2b cycle %0d: word=%h in_ready=%b", c, out_data, in_ready);
            tick();
            if (c == 3) in_valid = 1'b0;
        end
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle_valid got %b want 0", out_valid); else passed++;
        total++; if (blk_cnt !== 16'd4) $display("FAIL b2b_blk_cnt got %h want 0004", blk_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        in_data = BLK_A; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_data !== a_exp[1]) $display("FAIL rstmid_pre_data got %h want %h", out_data, a_exp[1]); else passed++;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 32'd0) $display("FAIL rstmid_data got %h want 00000000", out_data); else passed++;
        total++; if (blk_cnt !== 16'd0) $display("FAIL rstmid_blk_cnt got %h want 0000", blk_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        in_data = BLK_A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            total++; if (out_data !== a_exp[w]) $display("FAIL rstmid_data_w%0d got %h want %h", w, out_data, a_exp[w]); else passed++;
            $display("after reset word %0d: %h", w, out_data);
            tick();
        end
        total++; if (blk_cnt !== 16'd1) $display("FAIL rstmid_blk_cnt_after got %h want 0001", blk_cnt); else passed++;
    endtask

    // Emitting 65535 real blocks would take far too long, so the counter's
    // next value is pinned to 0xFFFF for one edge and then released.
    task automatic test_wrap();
        out_ready = 1'b0; in_valid = 1'b0;
        force dut.blk_cnt_d = 16'hFFFF;
        tick();
        release dut.blk_cnt_d;
        total++; if (blk_cnt !== 16'hFFFF) $display("FAIL wrap_preset got %h want ffff", blk_cnt); else passed++;
        in_data = BLK_B; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            total++; if (out_data !== b_exp[w]) $display("FAIL wrap_data_w%0d got %h want %h", w, out_data, b_exp[w]); else passed++;
            tick();
        end
        total++; if (blk_cnt !== 16'h0000) $display("FAIL wrap_blk_cnt got %h want 0000", blk_cnt); else passed++;
        $display("wrap: blk_cnt=%h", blk_cnt);
    endtask

    initial begin
`ifdef AES_SER_LSW_FIRST_EN
        a_exp = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        b_exp = '{32'h4B5A6978, 32'h0F1E2D3C, 32'h76543210, 32'hFEDCBA98};
`else
        a_exp = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        b_exp = '{32'hFEDCBA98, 32'h76543210, 32'h0F1E2D3C, 32'h4B5A6978};
`endif
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aes_block_serializer.md
AES_BLOCK_SERIALIZER -- requirements
Module: aes_block_serializer

Interface
REQ-001 Parameters: none; the input is fixed at 128 bits and the output at 32 bits.
REQ-002 clk  input  1  main clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  128  AES block to emit, bit 127 = MSB.
REQ-005 in_valid  input  1  in_data holds a block offered for capture.
REQ-006 in_ready  output  1  the block can accept in_data this cycle.
REQ-007 out_data  output  32  current word.
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_ready  input  1  the sink accepts out_data this cycle.
REQ-010 out_last  output  1  out_data is word 3 (final) of the block.
REQ-011 busy  output  1  a block is held and not fully emitted (state SEND).
REQ-012 blk_cnt  output  16  count of fully emitted blocks.

Function
REQ-013 The FSM SHALL have two states: IDLE and SEND.
REQ-014 A block transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; a word transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-015 In IDLE: in_ready=1, out_valid=0, out_last=0; on an in transfer the block SHALL be loaded into a 128-bit holding register, word index reset to 0, state -> SEND.
REQ-016 In SEND: out_valid=1; out_data=hold[127:96]; index counts 0..3.
REQ-017 On each out transfer with index<3: hold shifts left by 32 (zero fill), index increments.
REQ-018 out_last SHALL be 1 exactly when state=SEND and index=3.
REQ-019 On an out transfer with index=3: blk_cnt increments modulo 2^16 (0xFFFF -> 0x0000); if in_valid=1 in the same cycle, the new block loads, index=0 and the state stays SEND; otherwise state -> IDLE.
REQ-020 in_ready SHALL equal (state=IDLE) OR (state=SEND AND index=3 AND out_ready=1); this combinational path from out_ready is intentional and allows back-to-back blocks.
REQ-021 in_valid SHALL be ignored whenever in_ready=0; a block is never dropped or overwritten.
REQ-022 Latency: the first word of a block SHALL be valid on the cycle after its capture; with out_ready held at 1, the four words SHALL occupy four consecutive cycles.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and the state SHALL hold stable (no word skipped or repeated).
REQ-024 busy SHALL equal (state=SEND).

Reset
REQ-025 Asserting rst SHALL immediately force: state=IDLE, hold=0, index=0, blk_cnt=0, out_valid=0, out_last=0, out_data=0, busy=0, and in_ready=1 after release.
REQ-026 A reset mid-block SHALL discard remaining words; a partially emitted block SHALL NOT increment blk_cnt.

Configuration
REQ-027 Macro AES_SER_LSW_FIRST_EN: when defined, the block SHALL emit words least-significant first (out_data=hold[31:0], shift right by 32); when undefined, the block SHALL emit words most-significant first as in REQ-016/017.
REQ-028 The macro SHALL NOT change out_last, handshake, latency or blk_cnt behaviour.

Verification
REQ-029 Load 0x00112233_445566778_899AABB_CCDDEEFF read as 0x00112233445566778899AABBCCDDEEFF, out_ready=1 -> out_data 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles; out_last on the 4th only; blk_cnt=1; back to IDLE.
REQ-030 Same block, out_ready toggling 1,0,0,1,0,1,1 -> same 4 words in order, each held stable while stalled, no duplicates.
REQ-031 Two blocks A, B with in_valid held and out_ready=1 -> 8 words in 8 consecutive cycles; B captured on A's last-word cycle; blk_cnt=2.
REQ-032 rst pulsed after word 1 of a block -> out_valid=0 at once, blk_cnt=0; the next block emits from word 0.
REQ-033 Build with AES_SER_LSW_FIRST_EN, block of REQ-029 -> words CCDDEEFF, 8899AABB, 44556677, 00112233.
REQ-034 Force blk_cnt to 0xFFFF via 65535 blocks, then send one more block -> blk_cnt=0x0000.
